// File: rtl/mcycle_unit.sv
// mcycle_unit: iterative multiply/divide unit sitting beside the ALU in EX.
// One shift-add (multiply) or restoring shift-subtract (divide) step per
// cycle for WIDTH cycles. Signed operations work on magnitudes and the sign
// is fixed up on the way into DONE, so signedness costs no extra cycle.
module mcycle_unit #(
  parameter int WIDTH = 32
) (
  input  logic             CLK,
  input  logic             RESET_n,
  input  logic             Start,
  input  logic             Flush,
  input  logic [1:0]       MCycleOp,
  input  logic [WIDTH-1:0] Operand1,
  input  logic [WIDTH-1:0] Operand2,
  output logic [WIDTH-1:0] Result1,
  output logic [WIDTH-1:0] Result2,
  output logic             Busy,
  output logic             Done
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COMPUTE = 2'd1,
    ST_DONE    = 2'd2
  } state_t;

  state_t             state_reg, state_next;
  logic [CW-1:0]      count_reg;
  logic [2*WIDTH-1:0] acc_reg;      // multiply: {high, low}; divide: {remainder, quotient}
  logic [WIDTH-1:0]   opa_reg;      // multiplicand magnitude
  logic [WIDTH-1:0]   opb_reg;      // multiplier / divisor magnitude
  logic               op_div_reg;
  logic               neg_a_reg;    // operand sign bits, only set in signed mode
  logic               neg_b_reg;
  logic [WIDTH-1:0]   result1_reg, result2_reg;

  logic               start_ok;
  logic               last_iter;
  logic               neg_a_in, neg_b_in;
  logic [WIDTH-1:0]   mag_a_in, mag_b_in;

  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_step;
  logic [WIDTH:0]     div_trial;
  logic               div_ge;
  logic [WIDTH-1:0]   div_sub;
  logic [2*WIDTH-1:0] div_step;
  logic [2*WIDTH-1:0] acc_next;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   result1_next, result2_next;

  // A new operation is accepted only outside COMPUTE, and a flush always drops it
  assign start_ok  = Start && !Flush && (state_reg != ST_COMPUTE);
  assign last_iter = (state_reg == ST_COMPUTE) && !Flush && (count_reg == CW'(WIDTH - 1));

  assign neg_a_in = MCycleOp[1] & Operand1[WIDTH-1];
  assign neg_b_in = MCycleOp[1] & Operand2[WIDTH-1];
  // The most-negative value negates to itself, which read unsigned is 2^(WIDTH-1)
  assign mag_a_in = neg_a_in ? -Operand1 : Operand1;
  assign mag_b_in = neg_b_in ? -Operand2 : Operand2;

  // State register
  always_ff @(posedge CLK or negedge RESET_n) begin
    if (!RESET_n) state_reg <= ST_IDLE;
    else          state_reg <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE:    if (start_ok) state_next = ST_COMPUTE;
      ST_COMPUTE: begin
        if (Flush)          state_next = ST_IDLE;
        else if (last_iter) state_next = ST_DONE;
      end
      ST_DONE:    state_next = start_ok ? ST_COMPUTE : ST_IDLE;
      default:    state_next = ST_IDLE;
    endcase
  end

  // Outputs: Busy rises combinationally with an accepted Start so the issuer stalls at once
  always_comb begin
    Busy = (state_reg == ST_COMPUTE) || start_ok;
    Done = (state_reg == ST_DONE);
  end

  // One iteration of either algorithm, plus sign correction of its outcome
  always_comb begin
    // Shift-add: conditionally add the multiplicand to the high half, then shift right
    mul_sum  = {1'b0, acc_reg[2*WIDTH-1:WIDTH]} + {1'b0, opa_reg & {WIDTH{acc_reg[0]}}};
    mul_step = {mul_sum, acc_reg[WIDTH-1:1]};

    // Restoring divide: bring the next dividend bit into the remainder and trial-subtract
    div_trial = {acc_reg[2*WIDTH-1:WIDTH], acc_reg[WIDTH-1]};
    div_ge    = (div_trial >= {1'b0, opb_reg});
    div_sub   = div_trial[WIDTH-1:0] - opb_reg;
    div_step  = div_ge ? {div_sub, acc_reg[WIDTH-2:0], 1'b1}
                       : {div_trial[WIDTH-1:0], acc_reg[WIDTH-2:0], 1'b0};

    acc_next = op_div_reg ? div_step : mul_step;

    prod_fix = (neg_a_reg ^ neg_b_reg) ? -acc_next : acc_next;

    if (!op_div_reg) begin
      result1_next = prod_fix[WIDTH-1:0];
      result2_next = prod_fix[2*WIDTH-1:WIDTH];
    end else begin
      // Divide by zero yields all-ones quotient regardless of signs
      if (opb_reg == '0)
        result1_next = '1;
      else if (neg_a_reg ^ neg_b_reg)
        result1_next = -acc_next[WIDTH-1:0];
      else
        result1_next = acc_next[WIDTH-1:0];
      // Remainder follows the dividend's sign (truncating division)
      result2_next = neg_a_reg ? -acc_next[2*WIDTH-1:WIDTH] : acc_next[2*WIDTH-1:WIDTH];
    end
  end

  // Datapath registers: operand capture on Start, stepping in COMPUTE, results on the last step
  always_ff @(posedge CLK or negedge RESET_n) begin
    if (!RESET_n) begin
      count_reg   <= '0;
      acc_reg     <= '0;
      opa_reg     <= '0;
      opb_reg     <= '0;
      op_div_reg  <= 1'b0;
      neg_a_reg   <= 1'b0;
      neg_b_reg   <= 1'b0;
      result1_reg <= '0;
      result2_reg <= '0;
    end else if (start_ok) begin
      count_reg  <= '0;
      op_div_reg <= MCycleOp[0];
      neg_a_reg  <= neg_a_in;
      neg_b_reg  <= neg_b_in;
      opa_reg    <= mag_a_in;
      opb_reg    <= mag_b_in;
      // Multiply shifts the multiplier out of the low half; divide shifts the dividend
      acc_reg    <= MCycleOp[0] ? {{WIDTH{1'b0}}, mag_a_in} : {{WIDTH{1'b0}}, mag_b_in};
    end else if ((state_reg == ST_COMPUTE) && !Flush) begin
      acc_reg   <= acc_next;
      count_reg <= count_reg + CW'(1);
      if (last_iter) begin
        result1_reg <= result1_next;
        result2_reg <= result2_next;
      end
    end
  end

  assign Result1 = result1_reg;
  assign Result2 = result2_reg;

endmodule

// File: tb/tb_mcycle_unit.sv
// tb_mcycle_unit: directed and randomized checks of mcycle_unit against an
// arithmetic reference model (native 64-bit multiply / divide).
module tb_mcycle_unit;

  localparam int W = 32;

  logic          CLK = 1'b0;
  logic          RESET_n = 1'b0;
  logic          Start = 1'b0;
  logic          Flush = 1'b0;
  logic [1:0]    MCycleOp = 2'b00;
  logic [W-1:0]  Operand1 = '0;
  logic [W-1:0]  Operand2 = '0;
  logic [W-1:0]  Result1, Result2;
  logic          Busy, Done;

  int checks_total  = 0;
  int checks_passed = 0;

  mcycle_unit #(.WIDTH(W)) dut (
    .CLK      (CLK),
    .RESET_n  (RESET_n),
    .Start    (Start),
    .Flush    (Flush),
    .MCycleOp (MCycleOp),
    .Operand1 (Operand1),
    .Operand2 (Operand2),
    .Result1  (Result1),
    .Result2  (Result2),
    .Busy     (Busy),
    .Done     (Done)
  );

  always #5 CLK = ~CLK;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks_total++;
    if (obs === exp) checks_passed++;
    else $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Reference: returns {Result2, Result1}
  function automatic logic [63:0] model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    longint unsigned ua, ub;
    longint sa, sb, q, r;
    ua = {32'd0, a};
    ub = {32'd0, b};
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    if (op[0] == 1'b0) begin
      if (op[1]) return 64'(sa * sb);
      else       return 64'(ua * ub);
    end
    if (b == 32'd0) return {a, 32'hFFFF_FFFF};
    if (op[1]) begin
      q = sa / sb;
      r = sa % sb;
      return {r[31:0], q[31:0]};
    end
    return {32'(ua % ub), 32'(ua / ub)};
  endfunction

  // Present an operation; leaves the bench inside cycle 0
  task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b, input bit now);
    if (!now) begin
      @(posedge CLK); #1;
      check_val("idle_done_low", {63'd0, Done}, 64'd0);
    end
    Start = 1'b1; MCycleOp = op; Operand1 = a; Operand2 = b;
    #1;
    check_val("busy_cycle0", {63'd0, Busy}, 64'd1);
  endtask

  // Issue, track Busy/Done cycle by cycle, then check latency and results
  task automatic run_and_check(input string tag, input logic [1:0] op, input logic [31:0] a,
                               input logic [31:0] b, input logic [63:0] exp, input int repulse,
                               input bit now);
    int done_cyc = -1;
    int busy_bad = 0;
    issue(op, a, b, now);
    for (int c = 1; c <= 40; c++) begin
      @(posedge CLK); #1;
      if (c == 1) begin
        Start = 1'b0;
        Operand1 = $urandom; Operand2 = $urandom; MCycleOp = 2'($urandom_range(0, 3));
      end
      if (c == repulse)     Start = 1'b1;
      if (c == repulse + 1) Start = 1'b0;
      if (Done) begin done_cyc = c; break; end
      if (!Busy) busy_bad++;
    end
    check_val({tag, "_latency"}, 64'(done_cyc), 64'(W + 1));
    check_val({tag, "_busy"}, 64'(busy_bad), 64'd0);
    check_val({tag, "_busy_at_done"}, {63'd0, Busy}, 64'd0);
    check_val({tag, "_result"}, {Result2, Result1}, exp);
    $display("op=%0d a=0x%08h b=0x%08h -> R2=0x%08h R1=0x%08h done@%0d", op, a, b, Result2, Result1, done_cyc);
  endtask

  task automatic expect_quiet(input string tag, input int n);
    int seen = 0;
    repeat (n) begin
      @(posedge CLK); #1;
      if (Done) seen++;
    end
    check_val(tag, 64'(seen), 64'd0);
  endtask

  initial begin
    logic [63:0] prior;
    logic [1:0]  rop;
    logic [31:0] ra, rb;

    // Reset state
    #12;
    check_val("rst_r1", {32'd0, Result1}, 64'd0);
    check_val("rst_r2", {32'd0, Result2}, 64'd0);
    check_val("rst_done", {63'd0, Done}, 64'd0);
    check_val("rst_busy", {63'd0, Busy}, 64'd0);
    #6 RESET_n = 1'b1;

    // Directed arithmetic cases
    run_and_check("umul_max", 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, {32'hFFFF_FFFE, 32'h0000_0001}, 0, 0);
    run_and_check("smul_neg", 2'b10, 32'hFFFF_FFFD, 32'd7, {32'hFFFF_FFFF, 32'hFFFF_FFEB}, 0, 0);
    run_and_check("udiv", 2'b01, 32'd100, 32'd7, {32'd2, 32'd14}, 0, 0);
    run_and_check("sdiv_neg", 2'b11, 32'hFFFF_FF9C, 32'd7, {32'hFFFF_FFFE, 32'hFFFF_FFF2}, 0, 0);
    run_and_check("sdiv_ovf", 2'b11, 32'h8000_0000, 32'hFFFF_FFFF, {32'h0, 32'h8000_0000}, 0, 0);
    run_and_check("udiv_zero", 2'b01, 32'h0000_1234, 32'd0, {32'h0000_1234, 32'hFFFF_FFFF}, 0, 0);
    run_and_check("sdiv_zero", 2'b11, 32'hFFFF_FF00, 32'd0, {32'hFFFF_FF00, 32'hFFFF_FFFF}, 0, 0);
    run_and_check("smul_minneg", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, {32'h0, 32'h8000_0000}, 0, 0);

    // Start re-pulsed mid-computation is ignored
    run_and_check("repulse", 2'b00, 32'h0000_1234, 32'h10, {32'h0, 32'h0001_2340}, 5, 0);

    // Back-to-back: second Start issued in the Done cycle
    run_and_check("b2b_first", 2'b01, 32'd1000, 32'd9, {32'd1, 32'd111}, 0, 0);
    run_and_check("b2b_second", 2'b00, 32'd123, 32'd456, {32'd0, 32'd56088}, 0, 1);

    // Flush at cycle 10 aborts; results keep prior values
    prior = {Result2, Result1};
    issue(2'b00, 32'd5, 32'd9, 0);
    for (int c = 1; c <= 10; c++) begin
      @(posedge CLK); #1;
      if (c == 1) Start = 1'b0;
    end
    Flush = 1'b1;
    @(posedge CLK); #1;
    Flush = 1'b0;
    check_val("flush_busy", {63'd0, Busy}, 64'd0);
    check_val("flush_done", {63'd0, Done}, 64'd0);
    expect_quiet("flush_no_done", 40);
    check_val("flush_hold", {Result2, Result1}, prior);

    // Flush and Start together: Start dropped
    @(posedge CLK); #1;
    Start = 1'b1; Flush = 1'b1; MCycleOp = 2'b00; Operand1 = 32'd3; Operand2 = 32'd3;
    #1;
    check_val("flush_start_busy", {63'd0, Busy}, 64'd0);
    @(posedge CLK); #1;
    Start = 1'b0; Flush = 1'b0;
    check_val("flush_start_idle", {63'd0, Busy}, 64'd0);
    expect_quiet("flush_start_no_done", 40);
    check_val("flush_start_hold", {Result2, Result1}, prior);

    // Randomized operations against the model
    for (int i = 0; i < 24; i++) begin
      rop = 2'($urandom_range(0, 3));
      ra = $urandom;
      rb = $urandom;
      case ($urandom_range(0, 7))
        0: ra = 32'h8000_0000;
        1: ra = $urandom_range(0, 200);
        default: ;
      endcase
      case ($urandom_range(0, 7))
        0: rb = 32'd0;
        1: rb = 32'hFFFF_FFFF;
        2, 3: rb = $urandom_range(1, 50);
        default: ;
      endcase
      run_and_check("rand", rop, ra, rb, model(rop, ra, rb), 0, 0);
    end

    // Asynchronous reset mid-operation
    issue(2'b01, 32'd1000, 32'd3, 0);
    for (int c = 1; c <= 15; c++) begin
      @(posedge CLK); #1;
      if (c == 1) Start = 1'b0;
    end
    #2 RESET_n = 1'b0;
    #1;
    check_val("arst_r1", {32'd0, Result1}, 64'd0);
    check_val("arst_r2", {32'd0, Result2}, 64'd0);
    check_val("arst_busy", {63'd0, Busy}, 64'd0);
    check_val("arst_done", {63'd0, Done}, 64'd0);
    @(posedge CLK); #3;
    RESET_n = 1'b1;
    expect_quiet("arst_no_done", 40);
    run_and_check("arst_6x7", 2'b00, 32'd6, 32'd7, 64'd42, 0, 0);

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule

// File: doc/mcycle_unit.md
Name: mcycle_unit

Overview:
- Iterative multi-cycle multiply/divide unit in the execute stage, alongside the ALU.
- Takes the same Src_A/Src_B operands the ALU receives.
- Its Result1 is muxed with ALUResult into the EX/MEM register.
- Drives a Busy stall to the hazard unit while an operation is in flight.

Parameters:
- WIDTH, 32, operand width in bits. Also the iteration count.

Ports:
- CLK  input  1  system clock, rising edge.
- RESET_n  input  1  asynchronous, active-low reset.
- Start  input  1  request a new operation. Only honoured when not computing.
- Flush  input  1  abort the in-flight operation (pipeline flush).
- MCycleOp  input  2  bit0: 0=multiply, 1=divide. bit1: 0=unsigned, 1=signed.
- Operand1  input  WIDTH  multiplicand / dividend.
- Operand2  input  WIDTH  multiplier / divisor.
- Result1  output  WIDTH  product low word / quotient.
- Result2  output  WIDTH  product high word / remainder.
- Busy  output  1  stall request to the hazard unit.
- Done  output  1  one-cycle pulse; results are valid.

Behaviour:
- Clock and reset: single clock CLK. Reset is asynchronous, active-low on RESET_n.
- Reset values: state=IDLE, count=0, Result1=0, Result2=0, Done=0. Busy=0 whenever Start=0.
- States:
  - IDLE: waiting for Start.
  - COMPUTE: iterating.
  - DONE: results valid.
- IDLE or DONE with Start=1 (cycle 0):
  - Latch Operand1, Operand2 and MCycleOp; clear count; go to COMPUTE.
  - Busy=1 combinationally in cycle 0, so the issuing instruction stalls in the same cycle.
- COMPUTE:
  - One iteration per cycle over cycles 1..WIDTH; count runs 0..WIDTH-1.
  - Busy=1 throughout.
  - After the iteration with count=WIDTH-1, go to DONE.
- DONE (cycle WIDTH+1):
  - Done=1 and Busy=0 (unless Start=1 again).
  - Result1/Result2 are registered. They are stable from this cycle until the cycle after the next accepted Start.
  - Without Start, DONE returns to IDLE after one cycle. Results are held.
- Latency: Start at cycle 0 gives Done at cycle WIDTH+1 (33 for WIDTH=32).
- Start while in COMPUTE is ignored. The operation continues and the operands are not re-sampled.
- Flush:
  - In COMPUTE: go to IDLE next edge. No Done. Results keep their previous values.
  - Flush and Start in the same cycle: Flush wins and the Start is dropped.
- Multiply:
  - Shift-add over 2*WIDTH-bit accumulator.
  - Unsigned operands are used as given.
  - Signed mode multiplies magnitudes, then two's-complement negates the full 2*WIDTH product if the operand signs differ.
  - {Result2,Result1} = product.
- Divide:
  - Restoring shift-subtract, one quotient bit per iteration.
  - Signed mode divides magnitudes. The quotient is negated if the signs differ; the remainder takes the sign of the dividend (truncating division).
  - Magnitude of the most-negative value is treated as an unsigned 2^(WIDTH-1).
  - Signed 0x80000000 / -1 gives quotient 0x80000000, remainder 0.
- Divide by zero:
  - Runs the full WIDTH iterations, with no early exit.
  - Result1 = all ones, Result2 = dividend (unsigned and signed alike).
  - No exception flag.
- Sign correction is applied when entering DONE, so no extra cycle is added.
- Reset asserted mid-operation: immediate return to reset values. No Done pulse follows.
- Arithmetic is modulo 2^WIDTH per result word. No flags are produced; NZCV stays the ALU's responsibility.

Test Plan:
- Unsigned multiply: Op=00, 0xFFFFFFFF*0xFFFFFFFF -> Done at cycle 33, Result2=0xFFFFFFFE, Result1=0x00000001, Busy high cycles 0..32.
- Signed multiply: Op=10, -3 (0xFFFFFFFD) * 7 -> Result2=0xFFFFFFFF, Result1=0xFFFFFFEB.
- Divide:
  - Op=01, 100/7 -> Result1=14, Result2=2.
  - Op=11, -100/7 -> Result1=0xFFFFFFF2 (-14), Result2=0xFFFFFFFE (-2).
  - Op=11, 0x80000000/0xFFFFFFFF -> Result1=0x80000000, Result2=0.
- Divide by zero: Op=01, 0x1234/0 -> Done at cycle 33, Result1=0xFFFFFFFF, Result2=0x1234.
- Control:
  - Start re-pulsed at cycle 5 with new operands -> ignored; original result at cycle 33.
  - Flush at cycle 10 -> IDLE at cycle 11, no Done, Result1/Result2 keep prior values.
  - Back-to-back Start in the Done cycle -> the second operation completes 33 cycles later.
- Reset: RESET_n low at cycle 15 between clock edges -> outputs zero immediately. After release, a fresh 6*7 gives Result1=42 at Done.
